sar_scan_ctrl: RTL and testbench

Parametrised successive-approximation conversion sequencer for the chip's analogue front end. It drives an external resistor DAC word and, for each channel, decides one bit per trial from a per-channel comparator. It scans up to CHANNELS inputs (audio sample-and-hold, pots) and holds one result register per channel. It generalises the fixed audio SAR and fixed-threshold pot sensing into one block with configurable width, channel count, settle time, channel mask, and single-shot or continuous modes.

---
 rtl/sar_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sar_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_ctrl.sv
// Successive-approximation sequencer: scans the enabled comparator channels,
// resolves one DAC bit per settle window and keeps a result register per channel.
module sar_scan_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned SH_CYCLES = 2
) (
  input  logic                                               CLK_IN,
  input  logic                                               nRESET,
  input  logic                                               START,
  input  logic                                               CONT,
  input  logic [CHANNELS-1:0]                                CH_EN,
  input  logic [CHANNELS-1:0]                                COMP,
  output logic [WIDTH-1:0]                                   DAC_OUT,
  output logic                                               SH,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] CH_SEL,
  output logic                                               BUSY,
  output logic [CHANNELS*WIDTH-1:0]                          RESULTS,
  output logic [CHANNELS-1:0]                                CH_VALID,
  output logic                                               DONE
);

  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BIT_W   = $clog2(WIDTH);
  localparam int unsigned CNT_MAX = (SH_CYCLES > SETTLE) ? SH_CYCLES : SETTLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_TRIAL,
    S_STORE
  } state_e;

  state_e                    state_q, state_d;
  logic [CHANNELS-1:0]       mask_q, mask_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [WIDTH-1:0]          dac_q, dac_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] res_q, res_d;
  logic [CHANNELS-1:0]       vld_q, vld_d;

  logic                      start_any, next_any, comp_sel;
  logic [CH_W-1:0]           start_ch, next_ch;
  logic [WIDTH-1:0]          bit_mask, decided;

  assign bit_mask = WIDTH'(1) << bit_q;

  // Lowest enabled channel of the live mask (scan start) and next higher
  // channel of the latched mask (channel advance); descending loops let the
  // lowest match win.
  always_comb begin
    start_any = 1'b0;
    start_ch  = '0;
    next_any  = 1'b0;
    next_ch   = '0;
    comp_sel  = 1'b0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (CH_EN[i-1]) begin
        start_any = 1'b1;
        start_ch  = CH_W'(i - 1);
      end
      if (mask_q[i-1] && (CH_W'(i - 1) > ch_q)) begin
        next_any = 1'b1;
        next_ch  = CH_W'(i - 1);
      end
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (CH_W'(i) == ch_q) comp_sel = COMP[i];
    end
  end

  always_ff @(posedge CLK_IN or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      ch_q    <= '0;
      dac_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      dac_q   <= dac_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    dac_d   = dac_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    vld_d   = vld_q;
    decided = comp_sel ? dac_q : (dac_q & ~bit_mask);
    case (state_q)
      S_IDLE: begin
        if (START && start_any) begin
          mask_d  = CH_EN;
          ch_d    = start_ch;
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == CNT_W'(SH_CYCLES - 1)) begin
          cnt_d   = '0;
          dac_d   = {1'b1, {(WIDTH-1){1'b0}}};
          bit_d   = BIT_W'(WIDTH - 1);
          state_d = S_TRIAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRIAL: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            dac_d   = decided;
            state_d = S_STORE;
          end else begin
            dac_d = decided | (bit_mask >> 1);
            bit_d = bit_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (CH_W'(i) == ch_q) begin
            res_d[i*WIDTH +: WIDTH] = dac_q;
            vld_d[i]                = 1'b1;
          end
        end
        cnt_d = '0;
        if (next_any) begin
          ch_d    = next_ch;
          state_d = S_SAMPLE;
        end else if (CONT && start_any) begin
          mask_d  = CH_EN;
          ch_d    = start_ch;
          state_d = S_SAMPLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    DAC_OUT  = ((state_q == S_TRIAL) || (state_q == S_STORE)) ? dac_q : '0;
    SH       = (state_q == S_SAMPLE);
    BUSY     = (state_q != S_IDLE);
    DONE     = (state_q == S_STORE) && !next_any;
    CH_SEL   = ch_q;
    RESULTS  = res_q;
    CH_VALID = vld_q;
  end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Bench for sar_scan_ctrl: ideal comparators driven from per-channel levels,
// expected results/timing derived from the level values and enable masks.
module tb_sar_scan_ctrl;

  localparam int T1 = 2 + 8*2 + 1;
  localparam int T2 = 2 + 12*3 + 1;

  logic        clk = 1'b0;
  logic        nreset;
  always #5 clk = ~clk;

  logic        start1, cont1;
  logic [2:0]  ch_en1, comp1, vld1;
  logic [7:0]  dac1;
  logic        sh1, busy1, done1;
  logic [1:0]  chsel1;
  logic [23:0] res1;

  logic        start2, cont2;
  logic [4:0]  ch_en2, comp2, vld2;
  logic [11:0] dac2;
  logic        sh2, busy2, done2;
  logic [2:0]  chsel2;
  logic [59:0] res2;

  logic [7:0]  lvl1 [3];
  logic [11:0] lvl2 [5];
  logic [7:0]  exp_res [3];
  logic [2:0]  exp_vld;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  seq [$];
  logic        cap_en = 1'b0;

  sar_scan_ctrl u_dut1 (
    .CLK_IN(clk), .nRESET(nreset), .START(start1), .CONT(cont1),
    .CH_EN(ch_en1), .COMP(comp1), .DAC_OUT(dac1), .SH(sh1), .CH_SEL(chsel1),
    .BUSY(busy1), .RESULTS(res1), .CH_VALID(vld1), .DONE(done1)
  );

  sar_scan_ctrl #(.WIDTH(12), .CHANNELS(5), .SETTLE(3), .SH_CYCLES(2)) u_dut2 (
    .CLK_IN(clk), .nRESET(nreset), .START(start2), .CONT(cont2),
    .CH_EN(ch_en2), .COMP(comp2), .DAC_OUT(dac2), .SH(sh2), .CH_SEL(chsel2),
    .BUSY(busy2), .RESULTS(res2), .CH_VALID(vld2), .DONE(done2)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) comp1[i] = (lvl1[i] >= dac1);
    for (int i = 0; i < 5; i++) comp2[i] = (lvl2[i] >= dac2);
  end

  always @(negedge clk) begin
    if (cap_en && busy1 && !sh1 && !done1 && chsel1 == 2'd2) begin
      if (seq.size() == 0 || seq[$] != dac1) seq.push_back(dac1);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_vec();
    return {exp_res[2], exp_res[1], exp_res[0]};
  endfunction

  task automatic model_scan(input logic [2:0] mask);
    for (int i = 0; i < 3; i++) if (mask[i]) exp_res[i] = lvl1[i];
    exp_vld = exp_vld | mask;
  endtask

  task automatic start_scan1(input logic [2:0] mask);
    @(negedge clk);
    ch_en1 = mask;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input int from, output int cyc);
    cyc = from;
    while (done1 !== 1'b1 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int ndone;
    int exp_trial;
    logic [2:0] mask;
    logic [2:0] mid;

    nreset = 1'b0;
    start1 = 1'b0; cont1 = 1'b0; ch_en1 = '0;
    start2 = 1'b0; cont2 = 1'b0; ch_en2 = '0;
    for (int i = 0; i < 3; i++) begin lvl1[i] = '0; exp_res[i] = '0; end
    for (int i = 0; i < 5; i++) lvl2[i] = '0;
    exp_vld = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dac", 64'(dac1), 64'h0);
    check("rst_sh", 64'(sh1), 64'h0);
    check("rst_chsel", 64'(chsel1), 64'h0);
    check("rst_busy", 64'(busy1), 64'h0);
    check("rst_done", 64'(done1), 64'h0);
    check("rst_results", 64'(res1), 64'h0);
    check("rst_valid", 64'(vld1), 64'h0);
    @(negedge clk);
    nreset = 1'b1;

    // Default three-channel scan
    lvl1[0] = 8'h0A; lvl1[1] = 8'h35; lvl1[2] = 8'h44;
    start_scan1(3'b111);
    check("s1_busy_rise", 64'(busy1), 64'h1);
    check("s1_sh_rise", 64'(sh1), 64'h1);
    wait_done1(1, cyc);
    check("s1_done_cycle", 64'(cyc), 64'(3 * T1));
    model_scan(3'b111);
    @(posedge clk); #1;
    check("s1_done_pulse", 64'(done1), 64'h0);
    check("s1_busy_fall", 64'(busy1), 64'h0);
    check("s1_results", 64'(res1), 64'(exp_vec()));
    check("s1_valid", 64'(vld1), 64'(exp_vld));

    // Single channel 1, START held during BUSY, CH_EN changed mid-scan
    lvl1[0] = 8'h77; lvl1[1] = 8'($urandom);
    start_scan1(3'b010);
    ch_en1 = 3'b111;
    @(posedge clk); #1;
    check("s2_chsel", 64'(chsel1), 64'h1);
    start1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_done1(6, cyc);
    check("s2_done_cycle", 64'(cyc), 64'(T1));
    model_scan(3'b010);
    @(posedge clk); #1;
    check("s2_busy_fall", 64'(busy1), 64'h0);
    check("s2_results", 64'(res1), 64'(exp_vec()));

    // Boundary levels and DAC trial sequence on channel 2
    lvl1[0] = 8'h00; lvl1[1] = 8'hFF; lvl1[2] = 8'h80;
    seq.delete();
    cap_en = 1'b1;
    start_scan1(3'b111);
    wait_done1(1, cyc);
    cap_en = 1'b0;
    check("s3_done_cycle", 64'(cyc), 64'(3 * T1));
    model_scan(3'b111);
    @(posedge clk); #1;
    check("s3_results", 64'(res1), 64'(exp_vec()));
    check("s3_seq_len", 64'(seq.size()), 64'd8);
    for (int b = 7; b >= 0; b--) begin
      exp_trial = (int'(lvl1[2]) & ~((1 << (b + 1)) - 1)) | (1 << b);
      if (seq.size() > 7 - b) check("s3_trial_word", 64'(seq[7 - b]), 64'(exp_trial));
    end

    // START with an empty mask is ignored
    @(negedge clk);
    ch_en1 = 3'b000;
    start1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s4_busy_nomask", 64'(busy1), 64'h0);
    check("s4_sh_nomask", 64'(sh1), 64'h0);
    start1 = 1'b0;

    // Continuous mode, levels changed between scans, CONT dropped mid-scan
    for (int i = 0; i < 3; i++) lvl1[i] = 8'($urandom);
    cont1 = 1'b1;
    start_scan1(3'b111);
    wait_done1(1, cyc);
    check("s5_done1_cycle", 64'(cyc), 64'(3 * T1));
    model_scan(3'b111);
    for (int i = 0; i < 3; i++) lvl1[i] = 8'($urandom);
    @(posedge clk); #1;
    check("s5_done_pulse", 64'(done1), 64'h0);
    check("s5_sh_restart", 64'(sh1), 64'h1);
    check("s5_busy_held", 64'(busy1), 64'h1);
    check("s5_results1", 64'(res1), 64'(exp_vec()));
    repeat (10) @(posedge clk);
    #1;
    cont1 = 1'b0;
    wait_done1(11, cyc);
    check("s5_done2_cycle", 64'(cyc), 64'(3 * T1));
    model_scan(3'b111);
    @(posedge clk); #1;
    check("s5_busy_fall", 64'(busy1), 64'h0);
    check("s5_results2", 64'(res1), 64'(exp_vec()));
    ndone = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done1) ndone++;
    end
    check("s5_no_extra_done", 64'(ndone), 64'h0);
    check("s5_idle", 64'(busy1), 64'h0);

    // Random levels and masks, CH_EN scrambled after the scan starts
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) lvl1[i] = 8'($urandom);
      mask = 3'($urandom_range(1, 7));
      mid  = 3'($urandom_range(0, 7));
      start_scan1(mask);
      ch_en1 = mid;
      wait_done1(1, cyc);
      check("rnd_done_cycle", 64'(cyc), 64'($countones(mask) * T1));
      model_scan(mask);
      @(posedge clk); #1;
      check("rnd_busy_fall", 64'(busy1), 64'h0);
      check("rnd_results", 64'(res1), 64'(exp_vec()));
      check("rnd_valid", 64'(vld1), 64'(exp_vld));
    end

    // Asynchronous reset in the middle of a trial
    lvl1[0] = 8'h5A;
    start_scan1(3'b111);
    repeat (7) @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    check("s7_rst_dac", 64'(dac1), 64'h0);
    check("s7_rst_sh", 64'(sh1), 64'h0);
    check("s7_rst_chsel", 64'(chsel1), 64'h0);
    check("s7_rst_busy", 64'(busy1), 64'h0);
    check("s7_rst_done", 64'(done1), 64'h0);
    check("s7_rst_results", 64'(res1), 64'h0);
    check("s7_rst_valid", 64'(vld1), 64'h0);
    for (int i = 0; i < 3; i++) exp_res[i] = '0;
    exp_vld = '0;
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) lvl1[i] = 8'($urandom);
    start_scan1(3'b111);
    wait_done1(1, cyc);
    check("s8_done_cycle", 64'(cyc), 64'(3 * T1));
    model_scan(3'b111);
    @(posedge clk); #1;
    check("s8_results", 64'(res1), 64'(exp_vec()));
    check("s8_valid", 64'(vld1), 64'(exp_vld));

    // Wide instance: channel 4 only
    for (int i = 0; i < 5; i++) lvl2[i] = 12'($urandom);
    lvl2[4] = 12'hA5C;
    @(negedge clk);
    ch_en2 = 5'b10000;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("w_chsel", 64'(chsel2), 64'd4);
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w_done_cycle", 64'(cyc), 64'(T2));
    @(posedge clk); #1;
    check("w_busy_fall", 64'(busy2), 64'h0);
    check("w_results", 64'(res2), {4'h0, 12'hA5C, 48'h0});
    check("w_valid", 64'(vld2), 64'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
